// File: rtl/pick_pkg.sv
// Shared constants and state encoding for the pixel packet scheduler.
// Header words are fixed 16-bit patterns recognised by the downstream picker.
// No logic lives here; consumers import pick_pkg::*.
package pick_pkg;

  localparam logic [15:0] HDR_SYNC  = 16'hFFFF;
  localparam logic [15:0] HDR_MARK  = 16'hAAAA;
  localparam logic [15:0] CNTL_BASE = 16'hC000;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    HDR2,
    CNTL,
    PIX,
    GAP
  } pkt_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set req bit searching upward from last_grant+1.
// Latency: purely combinational, result valid in the same cycle.
// Backpressure: none; caller decides when to accept the grant.
module rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   grant,
  output logic               vld
);

  int idx;

  // Scan offsets from farthest to nearest so the nearest requester after
  // last_grant is the final (winning) assignment.
  always_comb begin
    grant = '0;
    vld   = 1'b0;
    idx   = 0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NUM_SRC;
      if (req[IDX_W'(idx)]) begin
        grant = IDX_W'(idx);
        vld   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_pkt_scheduler.sv
// Shares one pixel-packet picker among NUM_SRC line sources, one packet per grant.
// Latency: request seen in IDLE at edge n -> first sync word in cycle n+1, pixels from n+5.
// Backpressure: none downstream; sources must hold NUM_PIXEL words when requesting.
module pixel_pkt_scheduler
  import pick_pkg::*;
#(
  parameter int PIXEL_WIDTH = 16,
  parameter int NUM_SRC     = 4,
  parameter int NUM_PIXEL   = 16
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic                           enable,
  input  logic [NUM_SRC-1:0]             src_req,
  input  logic [NUM_SRC*PIXEL_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]             src_pop,
  output logic                           rcv_ready,
  output logic [PIXEL_WIDTH-1:0]         dout,
  output logic [$clog2(NUM_SRC)-1:0]     grant_id,
  output logic                           busy,
  output logic                           pkt_done
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(NUM_PIXEL + 1);

  pkt_state_t       state;
  pkt_state_t       state_nxt;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] arb_grant;
  logic             arb_vld;
  logic             take;
  logic [CNT_W-1:0] pix_cnt;

  logic [PIXEL_WIDTH-1:0] src_word [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign src_word[i] = src_data[i*PIXEL_WIDTH +: PIXEL_WIDTH];
  end

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req        (src_req),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .vld        (arb_vld)
  );

  // State register; reset aborts any packet in flight immediately.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // Latch the winner only when a new packet is actually started.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      grant_id   <= '0;
      last_grant <= IDX_W'(NUM_SRC - 1);
    end else if (take) begin
      grant_id   <= arb_grant;
      last_grant <= arb_grant;
    end
  end

  // Pixel counter: cleared during the control word, advances once per pixel.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)              pix_cnt <= '0;
    else if (state == CNTL) pix_cnt <= '0;
    else if (state == PIX)  pix_cnt <= pix_cnt + 1'b1;
  end

  // Next-state and output decode; requests are only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    dout      = '0;
    rcv_ready = 1'b0;
    src_pop   = '0;
    case (state)
      IDLE: begin
        if (enable && arb_vld) begin
          take      = 1'b1;
          state_nxt = HDR0;
        end
      end
      HDR0: begin
        dout      = HDR_SYNC;
        rcv_ready = 1'b1;
        state_nxt = HDR1;
      end
      HDR1: begin
        dout      = HDR_SYNC;
        state_nxt = HDR2;
      end
      HDR2: begin
        dout      = HDR_MARK;
        state_nxt = CNTL;
      end
      CNTL: begin
        dout      = CNTL_BASE | PIXEL_WIDTH'(grant_id);
        state_nxt = PIX;
      end
      PIX: begin
        dout              = src_word[grant_id];
        src_pop[grant_id] = 1'b1;
        if (pix_cnt == CNT_W'(NUM_PIXEL - 1)) state_nxt = GAP;
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign pkt_done = (state == GAP);

endmodule

// File: tb/tb_pixel_pkt_scheduler.sv
// Directed bench for pixel_pkt_scheduler with a show-ahead FIFO model per source.
// Each source's head word is {source+1, pops so far}, so pixel order and pop count are visible.
// Inputs are driven and outputs sampled on the falling edge.
module tb_pixel_pkt_scheduler;

  localparam int PW = 16;
  localparam int NS = 4;
  localparam int NP = 16;

  logic             CLK;
  logic             nRST;
  logic             enable;
  logic [NS-1:0]    src_req;
  logic [NS*PW-1:0] src_data;
  logic [NS-1:0]    src_pop;
  logic             rcv_ready;
  logic [PW-1:0]    dout;
  logic [1:0]       grant_id;
  logic             busy;
  logic             pkt_done;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [11:0] pop_cnt  [NS];
  logic [11:0] exp_pops [NS];

  pixel_pkt_scheduler #(
    .PIXEL_WIDTH (PW),
    .NUM_SRC     (NS),
    .NUM_PIXEL   (NP)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .enable    (enable),
    .src_req   (src_req),
    .src_data  (src_data),
    .src_pop   (src_pop),
    .rcv_ready (rcv_ready),
    .dout      (dout),
    .grant_id  (grant_id),
    .busy      (busy),
    .pkt_done  (pkt_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    for (int i = 0; i < NS; i++) pop_cnt[i] = '0;
  end

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NS; i++)
      if (src_pop[i]) pop_cnt[i] <= pop_cnt[i] + 12'd1;
  end

  always_comb begin
    src_data = '0;
    for (int i = 0; i < NS; i++)
      src_data[i*PW +: PW] = {4'(i + 1), pop_cnt[i]};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
  endtask

  // Advance until the HDR0 cycle (rcv_ready high) or give up after a bounded wait.
  task automatic wait_hdr(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 30 && !ok; t++) begin
      tick();
      if (rcv_ready === 1'b1) ok = 1'b1;
    end
    chk("hdr_seen", 32'(ok), 32'd1);
  endtask

  // Called in the HDR0 cycle; checks the whole packet and returns in the GAP cycle.
  task automatic run_pkt(input int id, input int en_drop, input bit req_drop);
    int pops;
    logic [NS-1:0] oh;
    pops = 0;
    oh   = NS'(1) << id;
    chk("hdr0", 32'(dout), 32'hFFFF);
    chk("hdr0_rdy", 32'(rcv_ready), 32'd1);
    chk("gid", 32'(grant_id), 32'(id));
    tick();
    if (req_drop) src_req = '0;
    chk("hdr1", 32'(dout), 32'hFFFF);
    chk("hdr1_rdy", 32'(rcv_ready), 32'd0);
    tick();
    chk("hdr2", 32'(dout), 32'hAAAA);
    tick();
    chk("cntl", 32'(dout), 32'hC000 | 32'(id));
    chk("cntl_pop", 32'(src_pop), 32'd0);
    for (int k = 0; k < NP; k++) begin
      tick();
      if (k == en_drop) enable = 1'b0;
      chk($sformatf("pix%0d_s%0d", k, id), 32'(dout),
          32'({4'(id + 1), 12'(exp_pops[id] + 12'(k))}));
      chk($sformatf("pop%0d", k), 32'(src_pop), 32'(oh));
      if (src_pop == oh) pops++;
    end
    exp_pops[id] = exp_pops[id] + 12'(NP);
    tick();
    chk("gap", 32'(dout), 32'd0);
    chk("gap_done", 32'(pkt_done), 32'd1);
    chk("gap_pop", 32'(src_pop), 32'd0);
    chk("pix_valid_cycles", 32'(pops), 32'(NP));
  endtask

  initial begin
    bit ok;
    int t_prev;
    for (int i = 0; i < NS; i++) exp_pops[i] = '0;
    nRST    = 1'b0;
    enable  = 1'b0;
    src_req = '0;

    // Reset state
    tick();
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_rdy", 32'(rcv_ready), 32'd0);
    chk("rst_pop", 32'(src_pop), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_done", 32'(pkt_done), 32'd0);
    tick();
    nRST = 1'b1;

    // Single requester 2: full packet, then back to idle
    enable  = 1'b1;
    src_req = 4'b0100;
    wait_hdr(ok);
    src_req = '0;
    run_pkt(2, -1, 1'b0);
    tick();
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_idle_done", 32'(pkt_done), 32'd0);

    // All requesting: 0,1,2,3,0 spaced 22 cycles apart
    do_reset();
    src_req = 4'b1111;
    t_prev  = 0;
    for (int g = 0; g < 5; g++) begin
      wait_hdr(ok);
      if (g > 0) chk($sformatf("period%0d", g), 32'(cyc - t_prev), 32'd22);
      t_prev = cyc;
      if (g == 4) src_req = '0;
      run_pkt(g % NS, -1, 1'b0);
    end

    // Wrap-around: last_grant=3 after reset, req 1001 -> 0 then 3
    do_reset();
    src_req = 4'b1001;
    wait_hdr(ok);
    run_pkt(0, -1, 1'b0);
    wait_hdr(ok);
    src_req = '0;
    run_pkt(3, -1, 1'b0);

    // enable dropped in PIX cycle 5: packet finishes, then stays idle
    src_req = 4'b0001;
    wait_hdr(ok);
    run_pkt(0, 4, 1'b0);
    for (int t = 0; t < 3; t++) begin
      tick();
      chk($sformatf("en_off_busy%0d", t), 32'(busy), 32'd0);
      chk($sformatf("en_off_dout%0d", t), 32'(dout), 32'd0);
    end
    src_req = '0;
    enable  = 1'b1;

    // src_req dropped during HDR1: packet unchanged
    src_req = 4'b0010;
    wait_hdr(ok);
    run_pkt(1, -1, 1'b1);
    tick();
    chk("req_drop_idle", 32'(busy), 32'd0);

    // Reset in PIX cycle 8, then the lowest requester wins
    src_req = 4'b1010;
    wait_hdr(ok);
    chk("rst_mid_gid", 32'(grant_id), 32'd3);
    tick();
    tick();
    tick();
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("rst_mid_pix%0d", k), 32'(dout),
          32'({4'd4, 12'(exp_pops[3] + 12'(k))}));
    end
    tick();
    nRST = 1'b0;
    #1;
    chk("arst_dout", 32'(dout), 32'd0);
    chk("arst_pop", 32'(src_pop), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_gid", 32'(grant_id), 32'd0);
    exp_pops[3] = exp_pops[3] + 12'd7;
    tick();
    chk("arst_pops", 32'(pop_cnt[3]), 32'(exp_pops[3]));
    nRST = 1'b1;
    wait_hdr(ok);
    src_req = '0;
    run_pkt(1, -1, 1'b0);
    tick();
    chk("final_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
